graphics_pixel_writer: RTL and testbench
========================================

Name: graphics_pixel_writer

Overview:
- Downstream stage of graphics_rect_fill and the other graphics primitive generators.
- Consumes the Avalon-ST pixel stream (pixel_t: x, y, color) and converts each pixel to a linear frame-buffer word address.
- Buffers pixels in a small FIFO and issues single-word writes on an Avalon-MM master port toward the frame-buffer arbiter.
- Decouples generator throughput from frame-buffer waitrequest stalls.

Parameters:
- H_RES, 640: horizontal resolution, in pixels per line.
- V_RES, 480: vertical resolution, in lines.
- FB_BASE, 0: word address of pixel (0,0).
- FB_ADDR_WIDTH, 19: width of the master address.
- FIFO_DEPTH, 4: pixel buffer depth. Must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clken  in  1  clock enable; all state advances only when high
- st_ready  out  1  sink ready
- st_data  in  pixel_t  pixel: x, y (COORD_DATA_WIDTH each), color (COLOR_DATA_WIDTH)
- st_valid  in  1  sink valid
- avm_address  out  FB_ADDR_WIDTH  frame-buffer word address
- avm_writedata  out  COLOR_DATA_WIDTH  pixel color
- avm_write  out  1  write request
- avm_waitrequest  in  1  slave stall
- busy  out  1  high while any accepted pixel is not yet written
- clip_count  out  16  pixels dropped by clipping. Present only with GRAPHICS_PIXEL_WRITER_CLIP_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk. Reset acts regardless of clken.
- Reset values:
  - FIFO is empty.
  - avm_write=0, avm_address=0, avm_writedata=0.
  - busy=0, clip_count=0.
  - st_ready=0 while reset is high.
- Accept: a beat is accepted on a rising edge where clken && st_valid && st_ready.
  - st_ready = !reset && (count < FIFO_DEPTH).
  - st_ready depends on the registered count only, never on a same-cycle pop.
  - A full FIFO therefore refuses input even when a pop is happening in that cycle.
- Address arithmetic:
  - addr = FB_BASE + y*H_RES + x.
  - Computed at full precision, then truncated to FB_ADDR_WIDTH.
  - The computed address and the color are written into the FIFO entry at accept time.
- Master side:
  - avm_write = FIFO non-empty, driven from a register.
  - avm_address and avm_writedata come from the head entry.
  - Pop occurs on a rising edge where clken && avm_write && !avm_waitrequest.
  - While avm_waitrequest=1, address, writedata and write are held stable.
  - Back-to-back pops are allowed: one write per cycle when waitrequest stays low.
- Latency: a pixel accepted at edge N is presented on the master at earliest after edge N (cycle N+1). Ordering is strictly FIFO.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Empty FIFO: avm_write=0. busy = (count != 0).
- clken low: no push, no pop, all registers hold, outputs hold their previous values.
- Reset mid-operation: all buffered pixels are discarded without being written, and avm_write drops on the next edge.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.

Optional Feature:
- Macro: GRAPHICS_PIXEL_WRITER_CLIP_EN.
- Defined:
  - A beat with x >= H_RES or y >= V_RES is accepted (st_ready obeys the normal rule) but not pushed.
  - clip_count increments by 1 for each such beat, saturating at 16'hFFFF.
  - busy is unaffected by clipped beats.
- Undefined:
  - No range check; every beat is pushed.
  - An out-of-range pixel is written at its truncated computed address.
  - The clip_count port does not exist.

Test Plan:
- Single pixel: after reset, send (x=3, y=2, color=16'h0AAA) with avm_waitrequest=0.
  - Required: next cycle avm_write=1, avm_address=1283, avm_writedata=16'h0AAA for exactly 1 cycle.
  - Then busy=0.
- Streaming: hold st_valid and waitrequest low and stream pixels (2..16, y=5).
  - Required: 15 consecutive writes at addresses 3202..3216, with st_ready constantly 1.
- Backpressure:
  - Hold avm_waitrequest=1 and push 5 pixels. Required: st_ready falls after 4 accepted; the 5th is held; avm_address is stable.
  - Release waitrequest. Required: all 5 pixels are written in order and busy falls after the last.
- clken gating: while writes are pending, hold clken=0 for 3 cycles.
  - Required: no pointer, count, or output change.
  - On clken=1, the sequence resumes unchanged.
- Mid-stream reset: with 3 pixels queued, assert reset for 1 cycle.
  - Required: avm_write=0, busy=0, st_ready=0 during reset.
  - st_ready=1 the cycle after reset; no queued pixels are written.
- Clipping (CLIP_EN): send (640,0), (0,480), (639,479).
  - Required: only address 307199 is written and clip_count=2.
  - Without the macro, 3 writes occur, to 640, 307200, and 307199.

Source files
------------

// File: rtl/graphics_pixel_writer.sv
// graphics_pixel_writer
//
// Purpose:
//   Turns a stream of pixels (x, y, color) into linear frame-buffer word
//   writes. Accepted pixels are converted to addr = FB_BASE + y*H_RES + x,
//   which is truncated to FB_ADDR_WIDTH. The address and color are buffered
//   in a small FIFO, and the FIFO head is issued as single-word Avalon-MM
//   writes. The FIFO absorbs waitrequest stalls so that the generator
//   upstream is not throttled by them.
//
// Optional feature (macro GRAPHICS_PIXEL_WRITER_CLIP_EN):
//   A beat outside the H_RES x V_RES screen is accepted but dropped.
//   clip_count counts the dropped beats and saturates at 16'hFFFF.
//   Without the macro every beat is written, and the clip_count port does
//   not exist.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset (acts regardless of clken)
//   clken            clock enable; all state advances only when high
//   st_ready         sink ready (depends on the registered count only)
//   st_data          pixel as {x, y, color}: x in the top COORD_DATA_WIDTH bits,
//                    then y, then color in the low COLOR_DATA_WIDTH bits
//   st_valid         sink valid
//   avm_address      frame-buffer word address (registered)
//   avm_writedata    pixel color (registered)
//   avm_write        write request (registered, high while the FIFO is non-empty)
//   avm_waitrequest  slave stall
//   busy             high while any accepted pixel is not yet written
//   clip_count       clipped-beat counter (CLIP_EN builds only)

module graphics_pixel_writer #(
    parameter int unsigned H_RES            = 640,
    parameter int unsigned V_RES            = 480,
    parameter int unsigned FB_BASE          = 0,
    parameter int unsigned FB_ADDR_WIDTH    = 19,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned COORD_DATA_WIDTH = 16,
    parameter int unsigned COLOR_DATA_WIDTH = 16
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            clken,
    output logic                                            st_ready,
    input  logic [2*COORD_DATA_WIDTH+COLOR_DATA_WIDTH-1:0]  st_data,
    input  logic                                            st_valid,
    output logic [FB_ADDR_WIDTH-1:0]                        avm_address,
    output logic [COLOR_DATA_WIDTH-1:0]                     avm_writedata,
    output logic                                            avm_write,
    input  logic                                            avm_waitrequest,
    output logic                                            busy
`ifdef GRAPHICS_PIXEL_WRITER_CLIP_EN
    ,
    output logic [15:0]                                     clip_count
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam int unsigned DW = 2 * COORD_DATA_WIDTH + COLOR_DATA_WIDTH;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || H_RES == 0 || V_RES == 0)
    begin : g_bad_param
        $error("graphics_pixel_writer: FIFO_DEPTH must be a power of 2 >= 2, resolution nonzero");
    end

    logic [COORD_DATA_WIDTH-1:0] w_x;
    logic [COORD_DATA_WIDTH-1:0] w_y;
    logic [COLOR_DATA_WIDTH-1:0] w_color;
    logic [FB_ADDR_WIDTH-1:0]    w_addr;
    logic                        w_clip;
    logic                        w_accept;
    logic                        w_push;
    logic                        w_pop;
    logic [PTR_W-1:0]            w_rd_ptr_nxt;
    logic [CNT_W-1:0]            w_count_nxt;
    logic [FB_ADDR_WIDTH-1:0]    w_head_addr;
    logic [COLOR_DATA_WIDTH-1:0] w_head_color;

    logic [FB_ADDR_WIDTH-1:0]    r_mem_addr  [FIFO_DEPTH];
    logic [COLOR_DATA_WIDTH-1:0] r_mem_color [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_count;
    logic                        r_avm_write;
    logic [FB_ADDR_WIDTH-1:0]    r_avm_address;
    logic [COLOR_DATA_WIDTH-1:0] r_avm_writedata;

    assign w_x     = st_data[DW-1 -: COORD_DATA_WIDTH];
    assign w_y     = st_data[COLOR_DATA_WIDTH +: COORD_DATA_WIDTH];
    assign w_color = st_data[COLOR_DATA_WIDTH-1:0];

    // Modular arithmetic: computing in FB_ADDR_WIDTH bits gives the same
    // result as computing at full precision and then truncating.
    assign w_addr = FB_ADDR_WIDTH'(FB_BASE)
                  + FB_ADDR_WIDTH'(w_y) * FB_ADDR_WIDTH'(H_RES)
                  + FB_ADDR_WIDTH'(w_x);

`ifdef GRAPHICS_PIXEL_WRITER_CLIP_EN
    assign w_clip = (32'(w_x) >= H_RES) || (32'(w_y) >= V_RES);
`else
    assign w_clip = 1'b0;
`endif

    assign st_ready = !reset && (r_count < DEPTH_C);
    assign w_accept = clken && st_valid && st_ready;
    assign w_push   = w_accept && !w_clip;
    assign w_pop    = clken && r_avm_write && !avm_waitrequest;

    assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // The next head can only coincide with the slot being written when the
    // incoming pixel is the sole valid entry, so forward it past the RAM.
    always_comb begin
        w_head_addr  = r_mem_addr[w_rd_ptr_nxt];
        w_head_color = r_mem_color[w_rd_ptr_nxt];
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_addr  = w_addr;
            w_head_color = w_color;
        end
    end

    // Storage is not reset; emptiness is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr]  <= w_addr;
            r_mem_color[r_wr_ptr] <= w_color;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_avm_write     <= 1'b0;
            r_avm_address   <= '0;
            r_avm_writedata <= '0;
        end else if (clken) begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_avm_write <= (w_count_nxt != '0);
            // When the FIFO drains, the last address and data stay on the bus.
            if (w_count_nxt != '0) begin
                r_avm_address   <= w_head_addr;
                r_avm_writedata <= w_head_color;
            end
        end
    end

`ifdef GRAPHICS_PIXEL_WRITER_CLIP_EN
    logic [15:0] r_clip_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clip_count <= '0;
        end else if (w_accept && w_clip && (r_clip_count != 16'hFFFF)) begin
            r_clip_count <= r_clip_count + 16'd1;
        end
    end

    assign clip_count = r_clip_count;
`endif

    assign avm_write     = r_avm_write;
    assign avm_address   = r_avm_address;
    assign avm_writedata = r_avm_writedata;
    assign busy          = (r_count != '0);

endmodule

// File: tb/tb_graphics_pixel_writer.sv
module tb_graphics_pixel_writer;

    localparam int unsigned H  = 640;
    localparam int unsigned V  = 480;
    localparam int unsigned AW = 19;
    localparam int unsigned CW = 16;
    localparam int unsigned DW = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  clken = 1'b1;
    logic                  st_ready;
    logic [2*CW+DW-1:0]    st_data = '0;
    logic                  st_valid = 1'b0;
    logic [AW-1:0]         avm_address;
    logic [DW-1:0]         avm_writedata;
    logic                  avm_write;
    logic                  avm_waitrequest = 1'b0;
    logic                  busy;
`ifdef GRAPHICS_PIXEL_WRITER_CLIP_EN
    logic [15:0]           clip_count;
`endif

    int n_vec    = 0;
    int n_fail   = 0;
    int n_writes = 0;
    logic [AW+DW-1:0] sb[$];

    graphics_pixel_writer #(
        .H_RES            (H),
        .V_RES            (V),
        .FB_BASE          (0),
        .FB_ADDR_WIDTH    (AW),
        .FIFO_DEPTH       (4),
        .COORD_DATA_WIDTH (CW),
        .COLOR_DATA_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clken           (clken),
        .st_ready        (st_ready),
        .st_data         (st_data),
        .st_valid        (st_valid),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy)
`ifdef GRAPHICS_PIXEL_WRITER_CLIP_EN
        ,
        .clip_count      (clip_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int unsigned x, input int unsigned y);
        logic [63:0] full;
        full = 64'(y) * 64'(H) + 64'(x);
        return full[AW-1:0];
    endfunction

    function automatic bit is_clipped(input int unsigned x, input int unsigned y);
`ifdef GRAPHICS_PIXEL_WRITER_CLIP_EN
        return (x >= H) || (y >= V);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one pixel, waits (bounded) for acceptance and records the
    // expected write. first_ready reports st_ready at the first sample.
    task automatic send_pixel(input int unsigned x, input int unsigned y,
                              input logic [DW-1:0] c, output bit first_ready);
        bit ok;
        ok = 1'b0;
        first_ready = 1'b0;
        st_data  = {CW'(x), CW'(y), c};
        st_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) first_ready = st_ready;
            if (st_ready && clken && !reset) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'(st_ready), 64'd1);
        @(posedge clk);
        #1;
        if (ok && !is_clipped(x, y)) sb.push_back({exp_addr(x, y), c});
        st_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            tick();
        end
        tick();
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every write that completes at the coming edge must match the
    // oldest outstanding expected pixel.
    always @(negedge clk) begin
        if (!reset && clken && avm_write && !avm_waitrequest) begin
            n_writes++;
            if (sb.size() == 0) check("unexpected_write", 64'(avm_address), 64'hFFFF_FFFF);
            else check("write", 64'({avm_address, avm_writedata}), 64'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fr;
        bit all_ready;
        int w0;

        // Reset state
        tick();
        @(negedge clk);
        check("rst_st_ready", 64'(st_ready), 64'd0);
        check("rst_avm_write", 64'(avm_write), 64'd0);
        check("rst_avm_address", 64'(avm_address), 64'd0);
        check("rst_avm_writedata", 64'(avm_writedata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
`ifdef GRAPHICS_PIXEL_WRITER_CLIP_EN
        check("rst_clip_count", 64'(clip_count), 64'd0);
`endif
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(st_ready), 64'd1);
        tick();

        // Single pixel
        w0 = n_writes;
        send_pixel(3, 2, 16'h0AAA, fr);
        check("single_write", 64'(avm_write), 64'd1);
        check("single_addr", 64'(avm_address), 64'd1283);
        check("single_data", 64'(avm_writedata), 64'h0AAA);
        tick();
        check("single_write_drop", 64'(avm_write), 64'd0);
        check("single_busy", 64'(busy), 64'd0);
        check("single_count", 64'(n_writes - w0), 64'd1);

        // Streaming
        w0 = n_writes;
        all_ready = 1'b1;
        for (int x = 2; x <= 16; x++) begin
            send_pixel(x, 5, 16'(16'h0100 + x), fr);
            if (!fr) all_ready = 1'b0;
        end
        check("stream_ready", 64'(all_ready), 64'd1);
        drain("stream");
        check("stream_writes", 64'(n_writes - w0), 64'd15);

        // Backpressure
        w0 = n_writes;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) send_pixel(10 + i, 7, 16'(16'h0200 + i), fr);
        check("bp_full_ready", 64'(st_ready), 64'd0);
        st_data  = {CW'(14), CW'(7), 16'h0204};
        st_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_ready", 64'(st_ready), 64'd0);
            check("bp_hold_addr", 64'(avm_address), 64'(exp_addr(10, 7)));
            check("bp_hold_write", 64'(avm_write), 64'd1);
        end
        tick();
        avm_waitrequest = 1'b0;
        send_pixel(14, 7, 16'h0204, fr);
        drain("bp");
        check("bp_writes", 64'(n_writes - w0), 64'd5);

        // clken gating
        w0 = n_writes;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) send_pixel(20 + i, 9, 16'(16'h0300 + i), fr);
        clken = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ce_write", 64'(avm_write), 64'd1);
            check("ce_addr", 64'(avm_address), 64'(exp_addr(20, 9)));
            check("ce_data", 64'(avm_writedata), 64'h0300);
            check("ce_busy", 64'(busy), 64'd1);
            check("ce_ready", 64'(st_ready), 64'd1);
        end
        check("ce_no_writes", 64'(n_writes - w0), 64'd0);
        clken = 1'b1;
        drain("ce");
        check("ce_writes", 64'(n_writes - w0), 64'd3);

        // Mid-stream reset
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) send_pixel(30 + i, 11, 16'(16'h0400 + i), fr);
        reset = 1'b1;
        @(negedge clk);
        check("mr_ready_low", 64'(st_ready), 64'd0);
        tick();
        reset = 1'b0;
        sb.delete();
        check("mr_write", 64'(avm_write), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_addr", 64'(avm_address), 64'd0);
        @(negedge clk);
        check("mr_ready_after", 64'(st_ready), 64'd1);
        tick();
        w0 = n_writes;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mr_no_writes", 64'(n_writes - w0), 64'd0);

        // Clipping boundaries
        w0 = n_writes;
        send_pixel(640, 0, 16'h0501, fr);
        send_pixel(0, 480, 16'h0502, fr);
        send_pixel(639, 479, 16'h0503, fr);
        drain("clip");
`ifdef GRAPHICS_PIXEL_WRITER_CLIP_EN
        check("clip_writes", 64'(n_writes - w0), 64'd1);
        check("clip_count", 64'(clip_count), 64'd2);
`else
        check("clip_writes", 64'(n_writes - w0), 64'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
